rx_line_buffer: RTL and testbench

- Sits between the AVR interface's serial receive/transmit ports and the top level; it is the interactive consumer of received bytes.
- Collects received characters into a line buffer, with backspace editing and overflow tracking.
- On carriage return, replays the buffered line to the serial transmitter, followed by CR LF, using the tx_data/new_tx_data/tx_busy handshake.
- Status outputs are intended for the onboard LEDs.

---
 rtl/rx_line_buffer.sv | 170 +++++++++++++++++
 tb/tb_rx_line_buffer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_line_buffer.sv
// rx_line_buffer: collects received serial bytes into a line buffer with
// backspace editing and overflow tracking. A carriage return replays the
// buffered line to the serial transmitter, followed by CR LF. The replay uses
// the tx_data/new_tx_data/tx_busy handshake. The status outputs drive LEDs.
module rx_line_buffer #(
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_data,
    input  logic                  new_rx_data,
    output logic [7:0]            tx_data,
    output logic                  new_tx_data,
    input  logic                  tx_busy,
    output logic [DEPTH_LOG2:0]   line_len,
    output logic                  overflow,
    output logic                  sending,
    output logic                  rx_drop,
    output logic                  line_done
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Full-buffer count: the top bit of the length register alone.
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;
    localparam logic [7:0] CHAR_BS = 8'h08;

    typedef enum logic [2:0] {
        COLLECT,
        SEND_BYTE,
        HOLD,
        SEND_CR,
        SEND_LF
    } state_t;

    state_t                state_reg;
    state_t                next_send_reg;   // state to enter once HOLD expires
    logic [DEPTH_LOG2:0]   len_reg;
    logic [DEPTH_LOG2:0]   index_reg;       // replay pointer; parked at 0 while collecting
    logic                  overflow_reg;
    logic                  sending_reg;
    logic                  rx_drop_reg;
    logic                  line_done_reg;
    logic [7:0]            tx_data_reg;
    logic                  new_tx_data_reg;

    logic [7:0]            mem [DEPTH];
    logic [7:0]            rd_data_reg;

    logic                  is_ctrl_char;
    logic                  wr_en;

    // A byte is written only when collecting, it is printable payload, and there is room.
    assign is_ctrl_char = (rx_data == CHAR_CR) || (rx_data == CHAR_LF) || (rx_data == CHAR_BS);
    assign wr_en        = (state_reg == COLLECT) && new_rx_data && !is_ctrl_char
                          && (len_reg != DEPTH_CNT);

    // Line storage with a registered read port. The read address follows
    // index_reg, which is stable for at least one cycle before every
    // SEND_BYTE decision (it sits at 0 during COLLECT and is updated on
    // entry to HOLD), so rd_data_reg always holds mem[index_reg] when used.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[len_reg[DEPTH_LOG2-1:0]] <= rx_data;
        end
        rd_data_reg <= mem[index_reg[DEPTH_LOG2-1:0]];
    end

    // Control FSM: line editing while collecting, then paced replay of the line plus CR LF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= COLLECT;
            next_send_reg   <= COLLECT;
            len_reg         <= '0;
            index_reg       <= '0;
            overflow_reg    <= 1'b0;
            sending_reg     <= 1'b0;
            rx_drop_reg     <= 1'b0;
            line_done_reg   <= 1'b0;
            tx_data_reg     <= 8'h00;
            new_tx_data_reg <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle unless re-asserted below.
            new_tx_data_reg <= 1'b0;
            line_done_reg   <= 1'b0;
            // Anything received while a line is being replayed is thrown away.
            rx_drop_reg     <= sending_reg && new_rx_data;

            case (state_reg)
                COLLECT: begin
                    if (new_rx_data) begin
                        if (rx_data == CHAR_CR) begin
                            sending_reg <= 1'b1;
                            index_reg   <= '0;
                            state_reg   <= (len_reg == '0) ? SEND_CR : SEND_BYTE;
                        end else if (rx_data == CHAR_LF) begin
                            // Line feeds from the terminal carry no meaning here.
                            state_reg <= COLLECT;
                        end else if (rx_data == CHAR_BS) begin
                            if (len_reg != '0) begin
                                len_reg <= len_reg - 1'b1;
                            end
                        end else if (len_reg != DEPTH_CNT) begin
                            len_reg <= len_reg + 1'b1;
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end
                end

                SEND_BYTE: begin
                    if (!tx_busy) begin
                        tx_data_reg     <= rd_data_reg;
                        new_tx_data_reg <= 1'b1;
                        index_reg       <= index_reg + 1'b1;
                        next_send_reg   <= ((index_reg + 1'b1) == len_reg) ? SEND_CR : SEND_BYTE;
                        state_reg       <= HOLD;
                    end
                end

                SEND_CR: begin
                    if (!tx_busy) begin
                        tx_data_reg     <= CHAR_CR;
                        new_tx_data_reg <= 1'b1;
                        next_send_reg   <= SEND_LF;
                        state_reg       <= HOLD;
                    end
                end

                SEND_LF: begin
                    if (!tx_busy) begin
                        tx_data_reg     <= CHAR_LF;
                        new_tx_data_reg <= 1'b1;
                        line_done_reg   <= 1'b1;
                        next_send_reg   <= COLLECT;
                        state_reg       <= HOLD;
                    end
                end

                HOLD: begin
                    // One blind cycle: the transmitter raises tx_busy a cycle
                    // after seeing the strobe, so tx_busy is not trusted here.
                    state_reg <= next_send_reg;
                    if (next_send_reg == COLLECT) begin
                        len_reg      <= '0;
                        index_reg    <= '0;
                        overflow_reg <= 1'b0;
                        sending_reg  <= 1'b0;
                    end
                end

                default: begin
                    state_reg <= COLLECT;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_reg;
    assign new_tx_data = new_tx_data_reg;
    assign line_len    = len_reg;
    assign overflow    = overflow_reg;
    assign sending     = sending_reg;
    assign rx_drop     = rx_drop_reg;
    assign line_done   = line_done_reg;

endmodule

// File: tb/tb_rx_line_buffer.sv
// tb_rx_line_buffer: drives directed and random serial traffic into
// rx_line_buffer and compares every output, every cycle, against a
// queue-based model of the line editor and replay pacing.
module tb_rx_line_buffer;

    localparam int DEPTH_LOG2 = 5;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [7:0]          rx_data = 8'h00;
    logic                new_rx_data = 1'b0;
    logic [7:0]          tx_data;
    logic                new_tx_data;
    logic                tx_busy = 1'b0;
    logic [DEPTH_LOG2:0] line_len;
    logic                overflow;
    logic                sending;
    logic                rx_drop;
    logic                line_done;

    int checks = 0;
    int failures = 0;

    rx_line_buffer #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .new_rx_data (new_rx_data),
        .tx_data     (tx_data),
        .new_tx_data (new_tx_data),
        .tx_busy     (tx_busy),
        .line_len    (line_len),
        .overflow    (overflow),
        .sending     (sending),
        .rx_drop     (rx_drop),
        .line_done   (line_done)
    );

    always #10 clk = ~clk;

    // ---------------- reference model ----------------
    // Line = queue of bytes; replay = queue of bytes still to emit.
    // A strobe is followed by one blind cycle before the next byte may go.
    logic [7:0] m_buf[$];
    logic [7:0] m_out[$];
    logic       m_sending = 1'b0;
    logic       m_ovf = 1'b0;
    logic       m_strobe = 1'b0;
    logic [7:0] m_tx = 8'h00;
    logic       m_done = 1'b0;
    logic       m_drop = 1'b0;
    int         cyc = 0;

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_buf.delete();
            m_out.delete();
            m_sending = 1'b0;
            m_ovf     = 1'b0;
            m_strobe  = 1'b0;
            m_tx      = 8'h00;
            m_done    = 1'b0;
            m_drop    = 1'b0;
        end else begin
            m_drop = m_sending && new_rx_data;
            m_done = 1'b0;
            if (m_sending) begin
                if (m_strobe) begin
                    m_strobe = 1'b0;
                    if (m_out.size() == 0) begin
                        m_sending = 1'b0;
                        m_ovf     = 1'b0;
                        m_buf.delete();
                    end
                end else if (!tx_busy) begin
                    m_tx     = m_out.pop_front();
                    m_strobe = 1'b1;
                    m_done   = (m_out.size() == 0);
                end
            end else if (new_rx_data) begin
                if (rx_data == 8'h0D) begin
                    m_out = m_buf;
                    m_out.push_back(8'h0D);
                    m_out.push_back(8'h0A);
                    m_sending = 1'b1;
                end else if (rx_data == 8'h0A) begin
                    m_sending = 1'b0;
                end else if (rx_data == 8'h08) begin
                    if (m_buf.size() > 0) void'(m_buf.pop_back());
                end else if (m_buf.size() < DEPTH) begin
                    m_buf.push_back(rx_data);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    logic chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx_data",     32'(tx_data),     32'(m_tx));
            chk("new_tx_data", 32'(new_tx_data), 32'(m_strobe));
            chk("line_len",    32'(line_len),    m_buf.size());
            chk("overflow",    32'(overflow),    32'(m_ovf));
            chk("sending",     32'(sending),     32'(m_sending));
            chk("rx_drop",     32'(rx_drop),     32'(m_drop));
            chk("line_done",   32'(line_done),   32'(m_done));
        end
    end

    // ---------------- transmitter emulation and logging ----------------
    logic       force_busy = 1'b0;
    logic       rand_busy = 1'b0;
    logic [7:0] log_q[$];
    int         log_cyc[$];
    int         drop_cnt = 0;

    always @(negedge clk) begin
        tx_busy = force_busy || (rand_busy && ($urandom_range(0, 2) == 0));
        if (new_tx_data === 1'b1) begin
            log_q.push_back(tx_data);
            log_cyc.push_back(cyc);
        end
        if (rx_drop === 1'b1) drop_cnt++;
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic rx(input logic [7:0] b);
        rx_data     = b;
        new_rx_data = 1'b1;
        @(negedge clk);
        new_rx_data = 1'b0;
        @(negedge clk);
    endtask

    task automatic rx_str(input string s);
        for (int i = 0; i < s.len(); i++) rx(s[i]);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sending !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("replay_timeout", 32'(sending), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_log(input int cnt);
        int n = 0;
        while (log_q.size() < cnt && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_timeout", 32'(log_q.size() >= cnt), 32'd1);
    endtask

    task automatic chk_log(input string name, input string exp);
        chk({name, "_count"}, log_q.size(), exp.len());
        for (int i = 0; i < exp.len() && i < log_q.size(); i++)
            chk({name, "_byte"}, 32'(log_q[i]), 32'(exp[i]));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_line_len", 32'(line_len), 32'd0);
        chk("reset_sending",  32'(sending),  32'd0);
        chk("reset_tx_data",  32'(tx_data),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // "Hi" CR with an idle transmitter: strobes 2 cycles apart.
        log_q.delete(); log_cyc.delete();
        rx_str("Hi");
        rx(8'h0D);
        wait_done();
        chk_log("hi", "Hi\r\n");
        for (int i = 0; i + 1 < log_cyc.size(); i++)
            chk("hi_spacing", log_cyc[i+1] - log_cyc[i], 32'd2);
        chk("hi_len_after", 32'(line_len), 32'd0);

        // Backspace editing, including backspace on an empty line.
        rx(8'h08);
        chk("bs_empty_len", 32'(line_len), 32'd0);
        log_q.delete();
        rx_str("abc");
        rx(8'h08);
        rx_str("d");
        chk("edit_len", 32'(line_len), 32'd3);
        rx(8'h0D);
        wait_done();
        chk_log("edit", "abd\r\n");

        // Overflow: 40 bytes into a 32-byte line.
        log_q.delete();
        for (int i = 0; i < 40; i++) rx(8'h41);
        chk("ovf_len", 32'(line_len), 32'd32);
        chk("ovf_flag", 32'(overflow), 32'd1);
        rx(8'h0D);
        wait_done();
        chk_log("ovf", {"AAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA", "\r\n"});
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Transmitter stalled after the first strobe; a byte arrives mid-send.
        log_q.delete(); drop_cnt = 0;
        rx_str("hello");
        rx(8'h0D);
        wait_log(1);
        force_busy = 1'b1;
        repeat (50) @(negedge clk);
        rx(8'h5A);
        repeat (48) @(negedge clk);
        chk("stall_strobes", log_q.size(), 32'd1);
        chk("stall_drops", drop_cnt, 32'd1);
        force_busy = 1'b0;
        wait_done();
        chk_log("stall", "hello\r\n");

        // Bare CR yields CR LF; a lone LF does nothing.
        log_q.delete();
        rx(8'h0D);
        wait_done();
        chk_log("bare_cr", "\r\n");
        log_q.delete();
        rx(8'h0A);
        repeat (6) @(negedge clk);
        chk("lf_no_strobe", log_q.size(), 32'd0);
        chk("lf_no_send", 32'(sending), 32'd0);

        // Reset in the middle of a replay.
        rx_str("hello");
        rx(8'h0D);
        wait_log(2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_sending",  32'(sending),     32'd0);
        chk("midrst_len",      32'(line_len),    32'd0);
        chk("midrst_strobe",   32'(new_tx_data), 32'd0);
        chk("midrst_tx_data",  32'(tx_data),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        log_q.delete();
        rx_str("x");
        rx(8'h0D);
        wait_done();
        chk_log("after_rst", "x\r\n");

        // Random traffic with a randomly busy transmitter.
        rand_busy = 1'b1;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                case ($urandom_range(0, 19))
                    0:       rx_data = 8'h0D;
                    1:       rx_data = 8'h08;
                    2:       rx_data = 8'h0A;
                    default: rx_data = 8'($urandom_range(32, 126));
                endcase
                new_rx_data = 1'b1;
            end else begin
                new_rx_data = 1'b0;
            end
            @(negedge clk);
        end
        new_rx_data = 1'b0;
        rand_busy = 1'b0;
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
